fp32_add_issuer: RTL and testbench

Request-side controller for the FP32 adder datapath. It accepts operand commands over a valid/ready interface and drives the adder's operand, sel and round_mode inputs. After a fixed adder latency it captures result, overflow and error into a response FIFO, then returns them in order over a second valid/ready interface. It also keeps a saturating overflow counter and a sticky error flag for software status.

---
 rtl/fp32_pkg.sv | 28 ++
 rtl/fp32_rsp_fifo.sv | 59 +++++
 rtl/fp32_add_issuer.sv | 128 ++++++++++++
 tb/tb_fp32_add_issuer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 constants and the response entry layout
// used by the adder request-side controller.
package fp32_pkg;

    localparam int FP32_W = 32;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [FP32_W-1:0] FP32_POS_INF = 32'h7F800000;
    localparam logic [FP32_W-1:0] FP32_MAX     = 32'h7F7FFFFF;

    typedef struct packed {
        logic [FP32_W-1:0] result;
        logic              overflow;
        logic              error;
    } rsp_entry_t;

    localparam int RSP_W = $bits(rsp_entry_t);

endpackage

// File: rtl/fp32_rsp_fifo.sv
// Show-ahead synchronous FIFO holding captured adder responses.
// Simultaneous push and pop are legal at any occupancy.
module fp32_rsp_fifo
    import fp32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = RSP_W,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fp32_add_issuer.sv
// Request-side controller for the FP32 adder: issues operands,
// captures results after a fixed latency, returns them in order.
module fp32_add_issuer
    import fp32_pkg::*;
#(
    parameter int ADD_LAT   = 1,
    parameter int RSP_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [FP32_W-1:0] cmd_a,
    input  logic [FP32_W-1:0] cmd_b,
    input  logic              cmd_sel,
    input  logic [1:0]        cmd_round_mode,
    output logic [FP32_W-1:0] add_a,
    output logic [FP32_W-1:0] add_b,
    output logic              add_sel,
    output logic [1:0]        add_round_mode,
    input  logic [FP32_W-1:0] add_result,
    input  logic              add_overflow,
    input  logic              add_error,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [FP32_W-1:0] rsp_result,
    output logic              rsp_overflow,
    output logic              rsp_error,
    input  logic              clear_status,
    output logic [CNT_W-1:0]  ovf_count,
    output logic              err_sticky,
    output logic              busy
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    logic [ADD_LAT-1:0] launch;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        used;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    rsp_entry_t         push_entry;
    rsp_entry_t         head;

    // in-flight commands hold a credit until their result is queued;
    // credits never exceed RSP_DEPTH so CW bits suffice
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ADD_LAT; i++)
            inflight = inflight + CW'(launch[i]);
    end

    assign used      = {1'b0, inflight} + {1'b0, fifo_count};
    assign cmd_ready = !reset && (used < (CW+1)'(RSP_DEPTH));
    assign accept    = cmd_valid && cmd_ready;

    assign push = launch[ADD_LAT-1];
    assign pop  = rsp_valid && rsp_ready;

    assign push_entry.result   = add_result;
    assign push_entry.overflow = add_overflow;
    assign push_entry.error    = add_error;

    // operand registers load on accept and hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            add_a          <= '0;
            add_b          <= '0;
            add_sel        <= 1'b0;
            add_round_mode <= 2'b00;
        end else if (accept) begin
            add_a          <= cmd_a;
            add_b          <= cmd_b;
            add_sel        <= cmd_sel;
            add_round_mode <= cmd_round_mode;
        end
    end

    // launch pipe marks which adder cycles carry a live command
    always_ff @(posedge clk) begin
        if (reset)
            launch <= '0;
        else
            launch <= (launch << 1) | ADD_LAT'(accept);
    end

    // status: clear wins but a same-edge push is still recorded
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clear_status) begin
            ovf_count  <= CNT_W'(push && add_overflow);
            err_sticky <= push && add_error;
        end else begin
            if (push && add_overflow && (ovf_count != '1))
                ovf_count <= ovf_count + 1'b1;
            if (push && add_error)
                err_sticky <= 1'b1;
        end
    end

    fp32_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (RSP_W),
        .CW    (CW)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign rsp_valid    = !fifo_empty;
    assign rsp_result   = head.result;
    assign rsp_overflow = head.overflow;
    assign rsp_error    = head.error;
    assign busy         = (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_fp32_add_issuer.sv
// Scoreboard bench for fp32_add_issuer with behavioural adder stubs.
// Instance a: ADD_LAT=1, CNT_W=16. Instance b: ADD_LAT=3, CNT_W=2.
module tb_fp32_add_issuer;
    import fp32_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [33:0] sb[$];

    logic        cmd_valid = 1'b0;
    logic        tgt = 1'b0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic        cmd_sel = 1'b0;
    logic [1:0]  cmd_rm = 2'b00;

    logic        a_reset = 1'b1;
    logic        a_cmd_valid;
    logic        a_cmd_ready;
    logic [31:0] a_add_a, a_add_b;
    logic        a_add_sel;
    logic [1:0]  a_add_rm;
    logic [31:0] a_res;
    logic        a_ovf, a_err;
    logic        a_rsp_valid;
    logic        a_rsp_ready = 1'b0;
    logic [31:0] a_rsp_result;
    logic        a_rsp_ovf, a_rsp_err;
    logic        a_clear = 1'b0;
    logic [15:0] a_ovf_count;
    logic        a_err_sticky;
    logic        a_busy;

    logic        b_reset = 1'b1;
    logic        b_cmd_valid;
    logic        b_cmd_ready;
    logic [31:0] b_add_a, b_add_b;
    logic        b_add_sel;
    logic [1:0]  b_add_rm;
    logic [33:0] b_s1 = '0;
    logic [33:0] b_s2 = '0;
    logic        b_rsp_valid;
    logic        b_rsp_ready = 1'b0;
    logic [31:0] b_rsp_result;
    logic        b_rsp_ovf, b_rsp_err;
    logic        b_clear = 1'b0;
    logic [1:0]  b_ovf_count;
    logic        b_err_sticky;
    logic        b_busy;

    assign a_cmd_valid = cmd_valid && !tgt;
    assign b_cmd_valid = cmd_valid && tgt;

    function automatic logic [33:0] stub(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
        if (a == FP32_POS_INF && b == FP32_POS_INF && s == OP_SUB)
            return {32'h7FC00000, 1'b0, 1'b1};
        if (a == FP32_MAX && b == FP32_MAX && s == OP_ADD)
            return {FP32_POS_INF, 1'b1, 1'b0};
        if (a == 32'h3F800000 && b == 32'h40000000 && s == OP_ADD)
            return {32'h40400000, 2'b00};
        return {(s ? a - b : a + b), 2'b00};
    endfunction

    assign {a_res, a_ovf, a_err} = stub(a_add_a, a_add_b, a_add_sel);

    // two register stages plus the capture edge give a 3-cycle adder
    always_ff @(posedge clk) begin
        b_s1 <= stub(b_add_a, b_add_b, b_add_sel);
        b_s2 <= b_s1;
    end

    fp32_add_issuer #(.ADD_LAT(1), .RSP_DEPTH(4), .CNT_W(16)) u_a (
        .clk(clk), .reset(a_reset),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_round_mode(cmd_rm),
        .add_a(a_add_a), .add_b(a_add_b), .add_sel(a_add_sel), .add_round_mode(a_add_rm),
        .add_result(a_res), .add_overflow(a_ovf), .add_error(a_err),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_result(a_rsp_result), .rsp_overflow(a_rsp_ovf), .rsp_error(a_rsp_err),
        .clear_status(a_clear), .ovf_count(a_ovf_count), .err_sticky(a_err_sticky),
        .busy(a_busy)
    );

    fp32_add_issuer #(.ADD_LAT(3), .RSP_DEPTH(4), .CNT_W(2)) u_b (
        .clk(clk), .reset(b_reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_round_mode(cmd_rm),
        .add_a(b_add_a), .add_b(b_add_b), .add_sel(b_add_sel), .add_round_mode(b_add_rm),
        .add_result(b_s2[33:2]), .add_overflow(b_s2[1]), .add_error(b_s2[0]),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_result(b_rsp_result), .rsp_overflow(b_rsp_ovf), .rsp_error(b_rsp_err),
        .clear_status(b_clear), .ovf_count(b_ovf_count), .err_sticky(b_err_sticky),
        .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // responses from instance a are popped and checked as they are consumed
    always @(negedge clk) begin
        if (!a_reset && a_rsp_valid && a_rsp_ready) begin
            chk("rsp_queued", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0)
                chk("rsp", 64'({a_rsp_result, a_rsp_ovf, a_rsp_err}), 64'(sb.pop_front()));
        end
    end

    task automatic issue(input bit t, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [1:0] rm, input logic [33:0] exp);
        int n;
        n = 0;
        tgt = t;
        cmd_a = a;
        cmd_b = b;
        cmd_sel = s;
        cmd_rm = rm;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!(t ? b_cmd_ready : a_cmd_ready) && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("issue_accept", 64'(t ? b_cmd_ready : a_cmd_ready), 64'd1);
        if (!t)
            sb.push_back(exp);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain;
        a_rsp_ready = 1'b1;
        for (int n = 0; n < 50 && sb.size() != 0; n++)
            @(negedge clk);
        @(posedge clk);
        #1;
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(a_cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_add_a", 64'(a_add_a), 64'd0);
        chk("rst_ovf", 64'(a_ovf_count), 64'd0);
        chk("rst_err", 64'(a_err_sticky), 64'd0);
        @(posedge clk);
        #1;
        a_reset = 1'b0;
        b_reset = 1'b0;
        #1;
        chk("post_rst_ready", 64'(a_cmd_ready), 64'd1);

        // basic add, one cycle of latency
        issue(0, 32'h3F800000, 32'h40000000, OP_ADD, RM_RNE, {32'h40400000, 2'b00});
        chk("lat_k", 64'(a_rsp_valid), 64'd0);
        chk("busy_inflight", 64'(a_busy), 64'd1);
        @(posedge clk);
        #1;
        chk("lat_k1", 64'(a_rsp_valid), 64'd1);
        drain();
        chk("idle_busy", 64'(a_busy), 64'd0);

        // back-pressure: four credits then stall
        a_rsp_ready = 1'b0;
        issue(0, 32'h100, 32'h5, OP_ADD, RM_RUP, {32'h105, 2'b00});
        issue(0, 32'h200, 32'h1, OP_SUB, RM_RTZ, {32'h1FF, 2'b00});
        chk("add_rm", 64'(a_add_rm), 64'(RM_RTZ));
        chk("add_sel", 64'(a_add_sel), 64'(OP_SUB));
        chk("add_b", 64'(a_add_b), 64'h1);
        issue(0, 32'h300, 32'h300, OP_ADD, RM_RDN, {32'h600, 2'b00});
        issue(0, 32'h7, 32'h7, OP_SUB, RM_RNE, {32'h0, 2'b00});
        chk("bp_full", 64'(a_cmd_ready), 64'd0);
        tgt = 1'b0;
        cmd_a = 32'h40;
        cmd_b = 32'h2;
        cmd_sel = OP_ADD;
        cmd_rm = RM_RNE;
        cmd_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_stall", 64'(a_cmd_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_cycle", 64'(a_cmd_ready), 64'd0);
        @(negedge clk);
        chk("bp_accept", 64'(a_cmd_ready), 64'd1);
        sb.push_back({32'h42, 2'b00});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        drain();

        // streaming: push and pop in the same cycle
        for (int i = 0; i < 8; i++)
            issue(0, 32'(i * 16), 32'h1, OP_ADD, RM_RNE, {32'(i * 16 + 1), 2'b00});
        drain();

        // overflow counting
        issue(0, FP32_MAX, FP32_MAX, OP_ADD, RM_RNE, {FP32_POS_INF, 1'b1, 1'b0});
        drain();
        chk("ovf_1", 64'(a_ovf_count), 64'd1);
        chk("ovf_err0", 64'(a_err_sticky), 64'd0);
        issue(0, FP32_MAX, FP32_MAX, OP_ADD, RM_RNE, {FP32_POS_INF, 1'b1, 1'b0});
        issue(0, FP32_MAX, FP32_MAX, OP_ADD, RM_RNE, {FP32_POS_INF, 1'b1, 1'b0});
        drain();
        chk("ovf_3", 64'(a_ovf_count), 64'd3);

        // error flag and clear
        issue(0, FP32_POS_INF, FP32_POS_INF, OP_SUB, RM_RNE, {32'h7FC00000, 1'b0, 1'b1});
        drain();
        chk("err_set", 64'(a_err_sticky), 64'd1);
        chk("err_ovf_kept", 64'(a_ovf_count), 64'd3);
        a_clear = 1'b1;
        @(posedge clk);
        #1;
        a_clear = 1'b0;
        chk("clr_err", 64'(a_err_sticky), 64'd0);
        chk("clr_ovf", 64'(a_ovf_count), 64'd0);

        // clear on the same edge as an overflow push
        issue(0, FP32_MAX, FP32_MAX, OP_ADD, RM_RNE, {FP32_POS_INF, 1'b1, 1'b0});
        drain();
        chk("pre_clr_ovf", 64'(a_ovf_count), 64'd1);
        a_rsp_ready = 1'b0;
        issue(0, FP32_MAX, FP32_MAX, OP_ADD, RM_RNE, {FP32_POS_INF, 1'b1, 1'b0});
        a_clear = 1'b1;
        @(posedge clk);
        #1;
        a_clear = 1'b0;
        chk("clr_push_ovf", 64'(a_ovf_count), 64'd1);
        chk("clr_push_err", 64'(a_err_sticky), 64'd0);
        drain();

        // saturation on a 2-bit counter
        b_rsp_ready = 1'b1;
        repeat (5) issue(1, FP32_MAX, FP32_MAX, OP_ADD, RM_RNE, '0);
        repeat (6) @(posedge clk);
        #1;
        chk("sat_cnt", 64'(b_ovf_count), 64'd3);
        chk("sat_idle", 64'(b_busy), 64'd0);

        // reset with two in flight and one queued
        b_rsp_ready = 1'b0;
        issue(1, 32'h10, 32'h1, OP_ADD, RM_RNE, '0);
        issue(1, 32'h20, 32'h1, OP_ADD, RM_RNE, '0);
        issue(1, 32'h30, 32'h1, OP_ADD, RM_RNE, '0);
        @(posedge clk);
        #1;
        chk("b_pre_valid", 64'(b_rsp_valid), 64'd1);
        chk("b_pre_head", 64'(b_rsp_result), 64'h11);
        b_reset = 1'b1;
        #1;
        chk("b_rst_ready", 64'(b_cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("b_rst_valid", 64'(b_rsp_valid), 64'd0);
        chk("b_rst_busy", 64'(b_busy), 64'd0);
        chk("b_rst_add_a", 64'(b_add_a), 64'd0);
        b_reset = 1'b0;
        #1;
        chk("b_post_ready", 64'(b_cmd_ready), 64'd1);
        b_rsp_ready = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (b_rsp_valid)
                stale++;
        end
        chk("b_no_stale", 64'(stale), 64'd0);

        chk("sb_left", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
